rop_csr_bank: RTL and testbench
===============================

// Module: rop_csr_bank
// PURPOSE
//  Multi-context ROP state bank: holds NUM_CTX independent copies of the ROP render state (rop_csrs_t).
//  Each context has a shadow copy, written by the CSR bus, and an active copy, which drives the ROP pipeline.
//  Shadow is copied to active only by an explicit commit handshake, and only once that context's pipeline has drained.
//  Sits between the core CSR write path and the ROP units; replaces the single flat rop_csrs_t register.
// PARAMETERS
//  NUM_CTX        4      number of render contexts (>=1, power of 2 not required)
//  CTX_BITS       clog2(NUM_CTX), min 1   context index width (derived localparam)
//  CSR_ADDR_BITS  12     CSR address width
//  CSR_BASE       12'h7C0  address of field 0; fields 0..16 occupy CSR_BASE..CSR_BASE+16
// PORTS
//  clk              in   1                 clock
//  reset_n          in   1                 async active-low reset
//  csr_wr_valid     in   1                 CSR write request
//  csr_wr_ready     out  1                 write accepted when valid&ready
//  csr_wr_ctx       in   CTX_BITS          target context
//  csr_wr_addr      in   CSR_ADDR_BITS     CSR address
//  csr_wr_data      in   32                write data
//  csr_wr_err       out  1                 1-cycle pulse: accepted write had bad addr/ctx
//  commit_valid     in   1                 commit request
//  commit_ready     out  1                 high only in IDLE
//  commit_ctx       in   CTX_BITS          context to commit
//  rop_idle         in   NUM_CTX           per-context pipeline drained
//  commit_done      out  1                 1-cycle pulse, new active state visible
//  commit_done_ctx  out  CTX_BITS          context of commit_done
//  active_csrs      out  NUM_CTX*ROP_CSRS_BITS   packed active rop_csrs_t per context
// BEHAVIOUR
//  Clocking and reset
//  - One clock. reset_n is asynchronous and active-low.
//  - Reset loads every shadow and active copy with ROP_CSRS_RESET.
//  - Reset drives FSM=IDLE, commit_done=0, commit_done_ctx=0, csr_wr_err=0.
//  - A reset arriving mid-commit aborts the commit; no partial copy survives.
//  CSR writes
//  - Field index = csr_wr_addr - CSR_BASE. Index 0..16 follows the rop_csrs_t order:
//    zbuf_addr, zbuf_pitch, cbuf_addr, cbuf_pitch, zfunc, sfunc, zfail, zpass, sfail,
//    blend_func_src_rgb, blend_func_dst_rgb, blend_func_src_a, blend_func_dst_a,
//    blend_mode_rgb, blend_mode_a, blend_const, logic_op.
//  - Data is truncated to the LSBs of the field width. Upper bits are ignored and no error is raised.
//  - The shadow field is updated at the accepting edge.
//  - Index out of range, or ctx>=NUM_CTX: the write is still accepted but dropped. csr_wr_err pulses the next cycle.
//  - csr_wr_ready=0 only while FSM=COPY and csr_wr_ctx==commit ctx. Otherwise it is 1.
//  Commit FSM (IDLE, DRAIN, COPY)
//  - IDLE: on commit_valid&commit_ready, latch ctx. Go to COPY if rop_idle[ctx], else DRAIN.
//    commit_ctx>=NUM_CTX: stay in IDLE and pulse no commit_done.
//  - DRAIN: wait until rop_idle[ctx]=1, then go to COPY. Writes to ctx are still accepted and land in this commit.
//  - COPY: one cycle. Active[ctx] <= shadow[ctx] at the end of the cycle, then return to IDLE.
//    commit_done=1 and commit_done_ctx=ctx are registered, so they assert in the first cycle the new active value is visible.
//  - Latency with rop_idle already high: request accepted in cycle T, COPY in T+1, active updated and commit_done in T+2.
//  - Contexts other than the committing one are never modified by a commit.
// CONFIGURATION
//  ROP_CSR_READBACK_EN defined:
//  - Adds ports csr_rd_valid in 1, csr_rd_ctx in CTX_BITS, csr_rd_addr in CSR_ADDR_BITS,
//    csr_rd_rsp_valid out 1, csr_rd_rsp_data out 32.
//  - The response returns one cycle after the request. It carries the shadow field, zero-extended.
//  - Bad index/ctx returns data 0. The response is never stalled.
//  - Read and write to the same field in the same cycle return the old value.
//  Undefined: readback ports, logic and response registers are absent.
// STRUCTURE
//  rop_types package gains:
//  - rop_csrs_t
//  - ROP_CSRS_BITS = $bits(rop_csrs_t)
//  - ROP_CSR_FIELD_* index constants 0..16 and ROP_CSR_NUM_FIELDS = 17
//  - ROP_CSRS_RESET: zeros, except zfunc/sfunc=ALWAYS and logic_op=COPY
//  - rop_commit_state_e enum {IDLE, DRAIN, COPY}
//  Sub-module rop_csr_field_wr: combinational field decode plus truncating merge of (rop_csrs_t, index, data).
//  It is shared by the write path and the readback mux.
// TESTING
//  1. Reset then idle: active_csrs==ROP_CSRS_RESET in every ctx; commit_ready=1; commit_done=0.
//  2. Write ctx1 blend_const=32'hDEADBEEF with rop_idle=all ones, then commit ctx1:
//     active[1].blend_const visible and commit_done_ctx=1 at T+2; ctx0/2/3 unchanged.
//  3. Commit ctx2 with rop_idle[2]=0 for 5 cycles, write zbuf_pitch=64 to ctx2 during DRAIN:
//     commit_ready=0 throughout; after idle rises, active[2].zbuf_pitch=64.
//  4. Write ctx0 during ctx0 COPY: csr_wr_ready=0 for that cycle, write lands after.
//     Write ctx3 in the same cycle: accepted, with no effect on the ctx0 commit.
//  5. Write addr CSR_BASE+17 with data 5: csr_wr_err pulse, no state change.
//     Write zfunc with 32'hFFFFFFFF: field holds all-ones of width ROP_DEPTH_FUNC_BITS.
//  6. Drop reset_n mid-DRAIN: outputs return to reset values immediately; next commit behaves as case 2.
//     With ROP_CSR_READBACK_EN defined, also read back shadow cbuf_addr: data arrives with a 1-cycle delay.

Source files
------------

// File: rtl/rop_types_pkg.sv
// ROP render-state types shared by the CSR bank and ROP units.
// Field widths, reset image, field indices and commit FSM states.
package rop_types_pkg;

  localparam int ROP_ADDR_BITS       = 32;
  localparam int ROP_PITCH_BITS      = 16;
  localparam int ROP_DEPTH_FUNC_BITS = 3;
  localparam int ROP_STENCIL_OP_BITS = 3;
  localparam int ROP_BLEND_FUNC_BITS = 5;
  localparam int ROP_BLEND_MODE_BITS = 3;
  localparam int ROP_LOGIC_OP_BITS   = 4;

  localparam logic [ROP_DEPTH_FUNC_BITS-1:0] ROP_DEPTH_ALWAYS = 3'd7;
  localparam logic [ROP_LOGIC_OP_BITS-1:0]   ROP_LOGIC_COPY   = 4'd3;

  typedef struct packed {
    logic [ROP_ADDR_BITS-1:0]       zbuf_addr;
    logic [ROP_PITCH_BITS-1:0]      zbuf_pitch;
    logic [ROP_ADDR_BITS-1:0]       cbuf_addr;
    logic [ROP_PITCH_BITS-1:0]      cbuf_pitch;
    logic [ROP_DEPTH_FUNC_BITS-1:0] zfunc;
    logic [ROP_DEPTH_FUNC_BITS-1:0] sfunc;
    logic [ROP_STENCIL_OP_BITS-1:0] zfail;
    logic [ROP_STENCIL_OP_BITS-1:0] zpass;
    logic [ROP_STENCIL_OP_BITS-1:0] sfail;
    logic [ROP_BLEND_FUNC_BITS-1:0] blend_func_src_rgb;
    logic [ROP_BLEND_FUNC_BITS-1:0] blend_func_dst_rgb;
    logic [ROP_BLEND_FUNC_BITS-1:0] blend_func_src_a;
    logic [ROP_BLEND_FUNC_BITS-1:0] blend_func_dst_a;
    logic [ROP_BLEND_MODE_BITS-1:0] blend_mode_rgb;
    logic [ROP_BLEND_MODE_BITS-1:0] blend_mode_a;
    logic [31:0]                    blend_const;
    logic [ROP_LOGIC_OP_BITS-1:0]   logic_op;
  } rop_csrs_t;

  localparam int ROP_CSRS_BITS    = $bits(rop_csrs_t);
  localparam int ROP_CSR_IDX_BITS = 5;

  localparam logic [4:0] ROP_CSR_FIELD_ZBUF_ADDR    = 5'd0;
  localparam logic [4:0] ROP_CSR_FIELD_ZBUF_PITCH   = 5'd1;
  localparam logic [4:0] ROP_CSR_FIELD_CBUF_ADDR    = 5'd2;
  localparam logic [4:0] ROP_CSR_FIELD_CBUF_PITCH   = 5'd3;
  localparam logic [4:0] ROP_CSR_FIELD_ZFUNC        = 5'd4;
  localparam logic [4:0] ROP_CSR_FIELD_SFUNC        = 5'd5;
  localparam logic [4:0] ROP_CSR_FIELD_ZFAIL        = 5'd6;
  localparam logic [4:0] ROP_CSR_FIELD_ZPASS        = 5'd7;
  localparam logic [4:0] ROP_CSR_FIELD_SFAIL        = 5'd8;
  localparam logic [4:0] ROP_CSR_FIELD_BF_SRC_RGB   = 5'd9;
  localparam logic [4:0] ROP_CSR_FIELD_BF_DST_RGB   = 5'd10;
  localparam logic [4:0] ROP_CSR_FIELD_BF_SRC_A     = 5'd11;
  localparam logic [4:0] ROP_CSR_FIELD_BF_DST_A     = 5'd12;
  localparam logic [4:0] ROP_CSR_FIELD_BM_RGB       = 5'd13;
  localparam logic [4:0] ROP_CSR_FIELD_BM_A         = 5'd14;
  localparam logic [4:0] ROP_CSR_FIELD_BLEND_CONST  = 5'd15;
  localparam logic [4:0] ROP_CSR_FIELD_LOGIC_OP     = 5'd16;
  localparam int         ROP_CSR_NUM_FIELDS         = 17;

  localparam rop_csrs_t ROP_CSRS_RESET = '{
    zfunc:    ROP_DEPTH_ALWAYS,
    sfunc:    ROP_DEPTH_ALWAYS,
    logic_op: ROP_LOGIC_COPY,
    default:  '0
  };

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    COPY
  } rop_commit_state_e;

endpackage

// File: rtl/rop_csr_field_wr.sv
// Field decode for one rop_csrs_t image: truncating merge of write data
// and zero-extended read of the addressed field.
module rop_csr_field_wr
  import rop_types_pkg::*;
(
  input  rop_csrs_t   i_csrs,
  input  logic [4:0]  i_idx,
  input  logic [31:0] i_data,
  output rop_csrs_t   o_csrs,
  output logic [31:0] o_rd,
  output logic        o_hit
);

  always_comb begin
    o_csrs = i_csrs;
    o_rd   = '0;
    o_hit  = 1'b1;
    unique case (i_idx)
      ROP_CSR_FIELD_ZBUF_ADDR: begin
        o_csrs.zbuf_addr = i_data[ROP_ADDR_BITS-1:0];
        o_rd = 32'(i_csrs.zbuf_addr);
      end
      ROP_CSR_FIELD_ZBUF_PITCH: begin
        o_csrs.zbuf_pitch = i_data[ROP_PITCH_BITS-1:0];
        o_rd = 32'(i_csrs.zbuf_pitch);
      end
      ROP_CSR_FIELD_CBUF_ADDR: begin
        o_csrs.cbuf_addr = i_data[ROP_ADDR_BITS-1:0];
        o_rd = 32'(i_csrs.cbuf_addr);
      end
      ROP_CSR_FIELD_CBUF_PITCH: begin
        o_csrs.cbuf_pitch = i_data[ROP_PITCH_BITS-1:0];
        o_rd = 32'(i_csrs.cbuf_pitch);
      end
      ROP_CSR_FIELD_ZFUNC: begin
        o_csrs.zfunc = i_data[ROP_DEPTH_FUNC_BITS-1:0];
        o_rd = 32'(i_csrs.zfunc);
      end
      ROP_CSR_FIELD_SFUNC: begin
        o_csrs.sfunc = i_data[ROP_DEPTH_FUNC_BITS-1:0];
        o_rd = 32'(i_csrs.sfunc);
      end
      ROP_CSR_FIELD_ZFAIL: begin
        o_csrs.zfail = i_data[ROP_STENCIL_OP_BITS-1:0];
        o_rd = 32'(i_csrs.zfail);
      end
      ROP_CSR_FIELD_ZPASS: begin
        o_csrs.zpass = i_data[ROP_STENCIL_OP_BITS-1:0];
        o_rd = 32'(i_csrs.zpass);
      end
      ROP_CSR_FIELD_SFAIL: begin
        o_csrs.sfail = i_data[ROP_STENCIL_OP_BITS-1:0];
        o_rd = 32'(i_csrs.sfail);
      end
      ROP_CSR_FIELD_BF_SRC_RGB: begin
        o_csrs.blend_func_src_rgb = i_data[ROP_BLEND_FUNC_BITS-1:0];
        o_rd = 32'(i_csrs.blend_func_src_rgb);
      end
      ROP_CSR_FIELD_BF_DST_RGB: begin
        o_csrs.blend_func_dst_rgb = i_data[ROP_BLEND_FUNC_BITS-1:0];
        o_rd = 32'(i_csrs.blend_func_dst_rgb);
      end
      ROP_CSR_FIELD_BF_SRC_A: begin
        o_csrs.blend_func_src_a = i_data[ROP_BLEND_FUNC_BITS-1:0];
        o_rd = 32'(i_csrs.blend_func_src_a);
      end
      ROP_CSR_FIELD_BF_DST_A: begin
        o_csrs.blend_func_dst_a = i_data[ROP_BLEND_FUNC_BITS-1:0];
        o_rd = 32'(i_csrs.blend_func_dst_a);
      end
      ROP_CSR_FIELD_BM_RGB: begin
        o_csrs.blend_mode_rgb = i_data[ROP_BLEND_MODE_BITS-1:0];
        o_rd = 32'(i_csrs.blend_mode_rgb);
      end
      ROP_CSR_FIELD_BM_A: begin
        o_csrs.blend_mode_a = i_data[ROP_BLEND_MODE_BITS-1:0];
        o_rd = 32'(i_csrs.blend_mode_a);
      end
      ROP_CSR_FIELD_BLEND_CONST: begin
        o_csrs.blend_const = i_data;
        o_rd = i_csrs.blend_const;
      end
      ROP_CSR_FIELD_LOGIC_OP: begin
        o_csrs.logic_op = i_data[ROP_LOGIC_OP_BITS-1:0];
        o_rd = 32'(i_csrs.logic_op);
      end
      default: o_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/rop_csr_bank.sv
// Multi-context ROP state bank: shadow/active copies with drained commit.
// Optional shadow readback port enabled by ROP_CSR_READBACK_EN.
module rop_csr_bank
  import rop_types_pkg::*;
#(
  parameter int NUM_CTX       = 4,
  parameter int CSR_ADDR_BITS = 12,
  parameter logic [CSR_ADDR_BITS-1:0] CSR_BASE = 12'h7C0,
  localparam int CTX_BITS = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
)(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       csr_wr_valid,
  output logic                       csr_wr_ready,
  input  logic [CTX_BITS-1:0]        csr_wr_ctx,
  input  logic [CSR_ADDR_BITS-1:0]   csr_wr_addr,
  input  logic [31:0]                csr_wr_data,
  output logic                       csr_wr_err,
  input  logic                       commit_valid,
  output logic                       commit_ready,
  input  logic [CTX_BITS-1:0]        commit_ctx,
  input  logic [NUM_CTX-1:0]         rop_idle,
  output logic                       commit_done,
  output logic [CTX_BITS-1:0]        commit_done_ctx,
`ifdef ROP_CSR_READBACK_EN
  input  logic                       csr_rd_valid,
  input  logic [CTX_BITS-1:0]        csr_rd_ctx,
  input  logic [CSR_ADDR_BITS-1:0]   csr_rd_addr,
  output logic                       csr_rd_rsp_valid,
  output logic [31:0]                csr_rd_rsp_data,
`endif
  output logic [NUM_CTX*ROP_CSRS_BITS-1:0] active_csrs
);

  function automatic logic ctx_ok(logic [CTX_BITS-1:0] c);
    return int'(c) < NUM_CTX;
  endfunction

  rop_commit_state_e   r_state, w_state_nxt;
  logic [CTX_BITS-1:0] r_ctx, w_ctx_nxt;
  rop_csrs_t           r_shadow [NUM_CTX];
  rop_csrs_t           r_active [NUM_CTX];
  logic                r_done;
  logic [CTX_BITS-1:0] r_done_ctx;
  logic                r_wr_err;

  logic [CSR_ADDR_BITS-1:0] w_wr_off;
  logic                     w_wr_ctx_ok;
  logic                     w_wr_idx_ok;
  logic                     w_wr_hit;
  logic                     w_wr_acc;
  logic                     w_wr_bad;
  logic                     w_wr_en;
  logic                     w_copy;
  rop_csrs_t                w_wr_cur;
  rop_csrs_t                w_wr_new;
  logic [31:0]              w_unused_wr_rd;

  assign w_wr_off    = csr_wr_addr - CSR_BASE;
  assign w_wr_idx_ok = w_wr_off < CSR_ADDR_BITS'(ROP_CSR_NUM_FIELDS);
  assign w_wr_ctx_ok = ctx_ok(csr_wr_ctx);
  assign w_wr_cur    = w_wr_ctx_ok ? r_shadow[csr_wr_ctx] : ROP_CSRS_RESET;

  rop_csr_field_wr u_wr_field (
    .i_csrs (w_wr_cur),
    .i_idx  (w_wr_off[4:0]),
    .i_data (csr_wr_data),
    .o_csrs (w_wr_new),
    .o_rd   (w_unused_wr_rd),
    .o_hit  (w_wr_hit)
  );

  // Only the context being copied this cycle back-pressures the bus.
  assign csr_wr_ready = !(r_state == COPY && csr_wr_ctx == r_ctx);
  assign w_wr_acc     = csr_wr_valid && csr_wr_ready;
  assign w_wr_bad     = !w_wr_idx_ok || !w_wr_hit || !w_wr_ctx_ok;
  assign w_wr_en      = w_wr_acc && !w_wr_bad;
  assign w_copy       = (r_state == COPY);

  always_comb begin
    w_state_nxt = r_state;
    w_ctx_nxt   = r_ctx;
    unique case (r_state)
      IDLE: begin
        if (commit_valid && ctx_ok(commit_ctx)) begin
          w_ctx_nxt   = commit_ctx;
          w_state_nxt = rop_idle[commit_ctx] ? COPY : DRAIN;
        end
      end
      DRAIN: begin
        if (rop_idle[r_ctx]) w_state_nxt = COPY;
      end
      COPY:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_ctx      <= '0;
      r_done     <= 1'b0;
      r_done_ctx <= '0;
      r_wr_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ctx      <= w_ctx_nxt;
      r_done     <= w_copy;
      r_done_ctx <= w_copy ? r_ctx : r_done_ctx;
      r_wr_err   <= w_wr_acc && w_wr_bad;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CTX; c++) begin
        r_shadow[c] <= ROP_CSRS_RESET;
        r_active[c] <= ROP_CSRS_RESET;
      end
    end else begin
      for (int c = 0; c < NUM_CTX; c++) begin
        if (w_wr_en && csr_wr_ctx == CTX_BITS'(c))
          r_shadow[c] <= w_wr_new;
        if (w_copy && r_ctx == CTX_BITS'(c))
          r_active[c] <= r_shadow[c];
      end
    end
  end

  for (genvar g = 0; g < NUM_CTX; g++) begin : g_act
    assign active_csrs[g*ROP_CSRS_BITS +: ROP_CSRS_BITS] = r_active[g];
  end

  assign commit_ready    = (r_state == IDLE);
  assign commit_done     = r_done;
  assign commit_done_ctx = r_done_ctx;
  assign csr_wr_err      = r_wr_err;

`ifdef ROP_CSR_READBACK_EN
  logic [CSR_ADDR_BITS-1:0] w_rd_off;
  logic                     w_rd_ok;
  logic                     w_rd_hit;
  rop_csrs_t                w_rd_cur;
  rop_csrs_t                w_unused_rd_csrs;
  logic [31:0]              w_rd_data;
  logic                     r_rd_valid;
  logic [31:0]              r_rd_data;

  assign w_rd_off = csr_rd_addr - CSR_BASE;
  assign w_rd_cur = ctx_ok(csr_rd_ctx) ? r_shadow[csr_rd_ctx] : ROP_CSRS_RESET;
  assign w_rd_ok  = ctx_ok(csr_rd_ctx) && w_rd_hit &&
                    (w_rd_off < CSR_ADDR_BITS'(ROP_CSR_NUM_FIELDS));

  rop_csr_field_wr u_rd_field (
    .i_csrs (w_rd_cur),
    .i_idx  (w_rd_off[4:0]),
    .i_data (32'h0),
    .o_csrs (w_unused_rd_csrs),
    .o_rd   (w_rd_data),
    .o_hit  (w_rd_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= csr_rd_valid;
      r_rd_data  <= (csr_rd_valid && w_rd_ok) ? w_rd_data : '0;
    end
  end

  assign csr_rd_rsp_valid = r_rd_valid;
  assign csr_rd_rsp_data  = r_rd_data;
`endif

endmodule

// File: tb/tb_rop_csr_bank.sv
// Directed self-checking bench for rop_csr_bank.
// Readback steps compile in when ROP_CSR_READBACK_EN is defined.
module tb_rop_csr_bank;
  import rop_types_pkg::*;

  localparam int NC = 4;
  localparam logic [11:0] BASE = 12'h7C0;

  logic        clk;
  logic        reset_n;
  logic        csr_wr_valid;
  logic        csr_wr_ready;
  logic [1:0]  csr_wr_ctx;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        csr_wr_err;
  logic        commit_valid;
  logic        commit_ready;
  logic [1:0]  commit_ctx;
  logic [3:0]  rop_idle;
  logic        commit_done;
  logic [1:0]  commit_done_ctx;
  logic [NC*ROP_CSRS_BITS-1:0] active_csrs;
`ifdef ROP_CSR_READBACK_EN
  logic        csr_rd_valid;
  logic [1:0]  csr_rd_ctx;
  logic [11:0] csr_rd_addr;
  logic        csr_rd_rsp_valid;
  logic [31:0] csr_rd_rsp_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  rop_csrs_t exp0, exp;

  rop_csr_bank dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .csr_wr_valid    (csr_wr_valid),
    .csr_wr_ready    (csr_wr_ready),
    .csr_wr_ctx      (csr_wr_ctx),
    .csr_wr_addr     (csr_wr_addr),
    .csr_wr_data     (csr_wr_data),
    .csr_wr_err      (csr_wr_err),
    .commit_valid    (commit_valid),
    .commit_ready    (commit_ready),
    .commit_ctx      (commit_ctx),
    .rop_idle        (rop_idle),
    .commit_done     (commit_done),
    .commit_done_ctx (commit_done_ctx),
`ifdef ROP_CSR_READBACK_EN
    .csr_rd_valid     (csr_rd_valid),
    .csr_rd_ctx       (csr_rd_ctx),
    .csr_rd_addr      (csr_rd_addr),
    .csr_rd_rsp_valid (csr_rd_rsp_valid),
    .csr_rd_rsp_data  (csr_rd_rsp_data),
`endif
    .active_csrs     (active_csrs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rop_csrs_t act(int c);
    return rop_csrs_t'(active_csrs[c*ROP_CSRS_BITS +: ROP_CSRS_BITS]);
  endfunction

  task automatic chk(string tag, logic [191:0] obs, logic [191:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] c, input logic [11:0] a,
                    input logic [31:0] d);
    csr_wr_valid = 1'b1;
    csr_wr_ctx   = c;
    csr_wr_addr  = a;
    csr_wr_data  = d;
    step();
    csr_wr_valid = 1'b0;
  endtask

  // Returns in the cycle after acceptance (COPY when rop_idle is high).
  task automatic commit_req(input logic [1:0] c);
    commit_ctx   = c;
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    csr_wr_valid = 1'b0;
    csr_wr_ctx   = '0;
    csr_wr_addr  = '0;
    csr_wr_data  = '0;
    commit_valid = 1'b0;
    commit_ctx   = '0;
    rop_idle     = 4'hF;
`ifdef ROP_CSR_READBACK_EN
    csr_rd_valid = 1'b0;
    csr_rd_ctx   = '0;
    csr_rd_addr  = '0;
`endif
    step();
    step();
    reset_n = 1'b1;
    step();

    // 1: reset state
    for (int c = 0; c < NC; c++)
      chk($sformatf("rst_active%0d", c), 192'(act(c)), 192'(ROP_CSRS_RESET));
    chk("rst_commit_ready", 192'(commit_ready), 192'(1'b1));
    chk("rst_commit_done", 192'(commit_done), 192'(1'b0));
    chk("rst_wr_ready", 192'(csr_wr_ready), 192'(1'b1));
    chk("rst_wr_err", 192'(csr_wr_err), 192'(1'b0));

    // 2: write ctx1 blend_const then commit with idle high
    wr(2'd1, BASE + 12'd15, 32'hDEADBEEF);
    chk("c2_shadow_only", 192'(act(1).blend_const), 192'(32'h0));
    commit_req(2'd1);
    chk("c2_copy_ready", 192'(commit_ready), 192'(1'b0));
    chk("c2_copy_done", 192'(commit_done), 192'(1'b0));
    chk("c2_copy_act", 192'(act(1).blend_const), 192'(32'h0));
    step();
    chk("c2_done", 192'(commit_done), 192'(1'b1));
    chk("c2_done_ctx", 192'(commit_done_ctx), 192'(2'd1));
    chk("c2_bconst", 192'(act(1).blend_const), 192'(32'hDEADBEEF));
    chk("c2_ctx0", 192'(act(0)), 192'(ROP_CSRS_RESET));
    chk("c2_ctx2", 192'(act(2)), 192'(ROP_CSRS_RESET));
    chk("c2_ctx3", 192'(act(3)), 192'(ROP_CSRS_RESET));
    step();
    chk("c2_done_pulse", 192'(commit_done), 192'(1'b0));

    // 3: commit ctx2 while its pipeline is busy, write during DRAIN
    rop_idle = 4'b1011;
    commit_req(2'd2);
    chk("c3_drain_ready1", 192'(commit_ready), 192'(1'b0));
    wr(2'd2, BASE + 12'd1, 32'd64);
    chk("c3_drain_ready2", 192'(commit_ready), 192'(1'b0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("c3_drain_ready_l%0d", i), 192'(commit_ready), 192'(1'b0));
      chk($sformatf("c3_drain_done_l%0d", i), 192'(commit_done), 192'(1'b0));
    end
    rop_idle = 4'hF;
    step();
    chk("c3_copy_ready", 192'(commit_ready), 192'(1'b0));
    chk("c3_copy_act", 192'(act(2).zbuf_pitch), 192'(16'd0));
    step();
    exp = ROP_CSRS_RESET;
    exp.zbuf_pitch = 16'd64;
    chk("c3_done", 192'(commit_done), 192'(1'b1));
    chk("c3_done_ctx", 192'(commit_done_ctx), 192'(2'd2));
    chk("c3_act2", 192'(act(2)), 192'(exp));
    chk("c3_ready_back", 192'(commit_ready), 192'(1'b1));

    // 4: write to the committing ctx stalls; other ctx is accepted
    commit_req(2'd0);
    csr_wr_valid = 1'b1;
    csr_wr_ctx   = 2'd0;
    csr_wr_addr  = BASE;
    csr_wr_data  = 32'h1234;
    #1;
    chk("c4_stall", 192'(csr_wr_ready), 192'(1'b0));
    step();
    chk("c4a_done", 192'(commit_done), 192'(1'b1));
    chk("c4a_act0", 192'(act(0)), 192'(ROP_CSRS_RESET));
    chk("c4_unstall", 192'(csr_wr_ready), 192'(1'b1));
    step();
    csr_wr_valid = 1'b0;
    chk("c4_wr_err", 192'(csr_wr_err), 192'(1'b0));
    commit_req(2'd0);
    csr_wr_valid = 1'b1;
    csr_wr_ctx   = 2'd3;
    csr_wr_addr  = BASE;
    csr_wr_data  = 32'h55;
    #1;
    chk("c4_other_ready", 192'(csr_wr_ready), 192'(1'b1));
    step();
    csr_wr_valid = 1'b0;
    chk("c4b_done", 192'(commit_done), 192'(1'b1));
    chk("c4b_zaddr0", 192'(act(0).zbuf_addr), 192'(32'h1234));
    chk("c4b_act3", 192'(act(3)), 192'(ROP_CSRS_RESET));
    commit_req(2'd3);
    step();
    chk("c4c_done_ctx", 192'(commit_done_ctx), 192'(2'd3));
    chk("c4c_zaddr3", 192'(act(3).zbuf_addr), 192'(32'h55));
    chk("c4c_zaddr0", 192'(act(0).zbuf_addr), 192'(32'h1234));

    // 5: out-of-range index, truncation
    exp0 = ROP_CSRS_RESET;
    exp0.zbuf_addr = 32'h1234;
    wr(2'd0, BASE + 12'd17, 32'd5);
    chk("c5_err_pulse", 192'(csr_wr_err), 192'(1'b1));
    step();
    chk("c5_err_clear", 192'(csr_wr_err), 192'(1'b0));
    wr(2'd0, BASE - 12'd1, 32'd5);
    chk("c5_err_below", 192'(csr_wr_err), 192'(1'b1));
    commit_req(2'd0);
    step();
    chk("c5_nochange", 192'(act(0)), 192'(exp0));
    wr(2'd0, BASE + 12'd4, 32'h8);
    chk("c5_trunc_err", 192'(csr_wr_err), 192'(1'b0));
    commit_req(2'd0);
    step();
    chk("c5_zfunc_8", 192'(act(0).zfunc), 192'(3'd0));
    wr(2'd0, BASE + 12'd4, 32'hFFFFFFFF);
    wr(2'd0, BASE + 12'd16, 32'hFFFFFFF9);
    commit_req(2'd0);
    step();
    exp0.logic_op = 4'h9;
    chk("c5_zfunc_ones", 192'(act(0).zfunc), 192'(3'h7));
    chk("c5_act0", 192'(act(0)), 192'(exp0));

    // 6: reset mid-DRAIN, then a clean commit
    rop_idle = 4'b1101;
    commit_req(2'd1);
    chk("c6_in_drain", 192'(commit_ready), 192'(1'b0));
    #2;
    reset_n = 1'b0;
    #1;
    chk("c6_rst_ready", 192'(commit_ready), 192'(1'b1));
    chk("c6_rst_done", 192'(commit_done), 192'(1'b0));
    chk("c6_rst_done_ctx", 192'(commit_done_ctx), 192'(2'd0));
    chk("c6_rst_act1", 192'(act(1)), 192'(ROP_CSRS_RESET));
    chk("c6_rst_act0", 192'(act(0)), 192'(ROP_CSRS_RESET));
    step();
    step();
    reset_n  = 1'b1;
    rop_idle = 4'hF;
    step();
    wr(2'd1, BASE + 12'd15, 32'hDEADBEEF);
    commit_req(2'd1);
    chk("c6_copy_done", 192'(commit_done), 192'(1'b0));
    step();
    exp = ROP_CSRS_RESET;
    exp.blend_const = 32'hDEADBEEF;
    chk("c6_done", 192'(commit_done), 192'(1'b1));
    chk("c6_done_ctx", 192'(commit_done_ctx), 192'(2'd1));
    chk("c6_act1", 192'(act(1)), 192'(exp));
    chk("c6_act2", 192'(act(2)), 192'(ROP_CSRS_RESET));

`ifdef ROP_CSR_READBACK_EN
    wr(2'd0, BASE + 12'd2, 32'hC0FFEE00);
    csr_rd_valid = 1'b1;
    csr_rd_ctx   = 2'd0;
    csr_rd_addr  = BASE + 12'd2;
    #1;
    chk("rb_no_rsp_yet", 192'(csr_rd_rsp_valid), 192'(1'b0));
    step();
    csr_rd_addr = BASE + 12'd20;
    chk("rb_rsp_valid", 192'(csr_rd_rsp_valid), 192'(1'b1));
    chk("rb_rsp_data", 192'(csr_rd_rsp_data), 192'(32'hC0FFEE00));
    step();
    csr_rd_valid = 1'b0;
    chk("rb_bad_data", 192'(csr_rd_rsp_data), 192'(32'h0));
    step();
    chk("rb_rsp_drop", 192'(csr_rd_rsp_valid), 192'(1'b0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
